// File: rtl/sar_adc_pkg.sv
// Shared types and defaults for the SAR ADC controller.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_WIDTH         = 10;
  localparam int DEF_SAMPLE_CYCLES = 2;
  localparam int DEF_SETTLE_CYCLES = 3;

  localparam logic [DEF_WIDTH-1:0] MIDSCALE = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_adc_if.sv
// Core-side and analog-side signals of the SAR ADC controller.
interface sar_adc_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             cont;
  logic             comp;
  logic             SAMPLE;
  logic [WIDTH-1:0] DAC_CODE;
  logic [WIDTH-1:0] DATA;
  logic             valid;
  logic             busy;

  modport master (
    output start, cont, comp,
    input  SAMPLE, DAC_CODE, DATA, valid, busy
  );

  modport slave (
    input  start, cont, comp,
    output SAMPLE, DAC_CODE, DATA, valid, busy
  );
endinterface

// File: rtl/sar_adc_ctrl_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; only the second one is safe to use.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: track/hold, binary search on the DAC code, result hand-off.
//
//   state   | meaning
//   IDLE    | waiting for start or cont, outputs quiet
//   TRACK   | SAMPLE high, input tracked for SAMPLE_CYCLES cycles
//   CONVERT | one bit per SETTLE_CYCLES cycles, MSB first
//   DONE    | valid pulse, DATA carries the result; restart if cont
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input logic      CLK,
  input logic      reset,
  sar_adc_if.slave bus
);

  localparam int SMP_W = cnt_w(SAMPLE_CYCLES);
  localparam int SET_W = cnt_w(SETTLE_CYCLES);
  localparam int IDX_W = cnt_w(WIDTH);

  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MID_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t r_state, w_state_n;

  logic [SMP_W-1:0] r_smp_cnt, w_smp_cnt_n;
  logic [SET_W-1:0] r_set_cnt, w_set_cnt_n;
  logic [IDX_W-1:0] r_idx,     w_idx_n;
  logic [WIDTH-1:0] r_dac,     w_dac_n;
  logic [WIDTH-1:0] r_data,    w_data_n;
  logic             r_sample,  w_sample_n;
  logic             r_valid,   w_valid_n;
  logic             r_busy,    w_busy_n;

  logic             w_comp_s;
  logic             w_go;
  logic             w_smp_last;
  logic             w_bit_last;
  logic             w_idx_zero;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_sel_lo;
  logic [WIDTH-1:0] w_dac_dec;

  sync_2ff u_comp_sync (
    .i_clk   (CLK),
    .i_rst_n (reset),
    .i_d     (bus.comp),
    .o_q     (w_comp_s)
  );

  assign w_go       = bus.start | bus.cont;
  assign w_smp_last = (r_smp_cnt == SMP_LAST);
  assign w_bit_last = (r_set_cnt == SET_LAST);
  assign w_idx_zero = (r_idx == '0);

  // Bit decision is pure masking: keep/clear the bit under test, raise the next trial bit.
  assign w_sel     = ONE_HOT0 << r_idx;
  assign w_sel_lo  = w_sel >> 1;
  assign w_dac_dec = (r_dac & ~w_sel) | (w_comp_s ? w_sel : '0) | w_sel_lo;

  // State and all registered outputs/counters.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_smp_cnt <= '0;
      r_set_cnt <= '0;
      r_idx     <= '0;
      r_dac     <= '0;
      r_data    <= '0;
      r_sample  <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_smp_cnt <= w_smp_cnt_n;
      r_set_cnt <= w_set_cnt_n;
      r_idx     <= w_idx_n;
      r_dac     <= w_dac_n;
      r_data    <= w_data_n;
      r_sample  <= w_sample_n;
      r_valid   <= w_valid_n;
      r_busy    <= w_busy_n;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (w_go) w_state_n = TRACK;
      TRACK:   if (w_smp_last) w_state_n = CONVERT;
      CONVERT: if (w_bit_last && w_idx_zero) w_state_n = DONE;
      DONE:    w_state_n = bus.cont ? TRACK : IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Next values of outputs, counters and the SAR register.
  always_comb begin
    w_smp_cnt_n = r_smp_cnt;
    w_set_cnt_n = r_set_cnt;
    w_idx_n     = r_idx;
    w_dac_n     = r_dac;
    w_data_n    = r_data;
    w_sample_n  = 1'b0;
    w_valid_n   = 1'b0;
    w_busy_n    = r_busy;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_sample_n  = 1'b1;
          w_busy_n    = 1'b1;
          w_smp_cnt_n = '0;
        end
      end
      TRACK: begin
        if (w_smp_last) begin
          w_idx_n     = IDX_MSB;
          w_dac_n     = MID_CODE;
          w_set_cnt_n = '0;
        end else begin
          w_sample_n  = 1'b1;
          w_smp_cnt_n = r_smp_cnt + SMP_W'(1);
        end
      end
      CONVERT: begin
        if (w_bit_last) begin
          w_dac_n     = w_dac_dec;
          w_set_cnt_n = '0;
          if (w_idx_zero) begin
            // Result is latched on entry to DONE so valid and DATA line up.
            w_data_n  = w_dac_dec;
            w_valid_n = 1'b1;
          end else begin
            w_idx_n = r_idx - IDX_W'(1);
          end
        end else begin
          w_set_cnt_n = r_set_cnt + SET_W'(1);
        end
      end
      DONE: begin
        if (bus.cont) begin
          w_sample_n  = 1'b1;
          w_smp_cnt_n = '0;
        end else begin
          w_busy_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.SAMPLE   = r_sample;
  assign bus.DAC_CODE = r_dac;
  assign bus.DATA     = r_data;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl with an ideal comparator model.
module tb_sar_adc_ctrl;
  localparam int W   = 10;
  localparam int LAT = 33;          // 2 + 10*3 + 1
  localparam int LAT2 = 55;         // 4 + 10*5 + 1

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic CLK   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   errors = 0;
  int   checks = 0;

  logic [W-1:0] vin1 = '0;
  logic [W-1:0] vin2 = '0;

  exp_t sb[$];
  exp_t e;
  logic         prev_valid = 1'b0;
  logic [W-1:0] prev_data  = '0;

  sar_adc_if #(.WIDTH(W)) if1 ();
  sar_adc_if #(.WIDTH(W)) if2 ();

  assign if1.comp = (vin1 >= if1.DAC_CODE);
  assign if2.comp = (vin2 >= if2.DAC_CODE);

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(3)) dut1 (
    .CLK   (CLK),
    .reset (reset),
    .bus   (if1)
  );

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(5)) dut2 (
    .CLK   (CLK),
    .reset (reset),
    .bus   (if2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Successive approximation against an ideal comparator, done as plain arithmetic.
  function automatic logic [W-1:0] sar_ref(input logic [W-1:0] v);
    logic [W-1:0] code;
    logic [W-1:0] trial;
    code = '0;
    for (int i = W - 1; i >= 0; i--) begin
      trial = code | (W'(1) << i);
      if (v >= trial) code = trial;
    end
    return code;
  endfunction

  // Called at a falling edge; start is sampled at the next rising edge.
  task automatic issue(input logic [W-1:0] v);
    exp_t x;
    vin1 = v;
    if1.start = 1'b1;
    x.data = sar_ref(v);
    x.cyc  = cyc + LAT;
    sb.push_back(x);
    @(negedge CLK);
    if1.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || if1.busy) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0 || if1.busy) begin
      errors++;
      checks++;
      $display("FAIL wait_done: timeout after %0d cycles, pending=%0d busy=%0b", n, sb.size(), if1.busy);
      sb.delete();
    end
  endtask

  // Monitor: every valid must match the oldest expected result, at the expected cycle.
  always @(negedge CLK) begin
    if (!reset) begin
      prev_valid = 1'b0;
      prev_data  = '0;
    end else begin
      if (if1.valid) begin
        chk("valid_single_cycle", 32'(prev_valid), 32'd0);
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_valid: DATA=%0h at cycle %0d, expected no valid", if1.DATA, cyc);
        end else begin
          e = sb.pop_front();
          chk("data", 32'(if1.DATA), 32'(e.data));
          chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (if1.DATA !== prev_data) begin
        chk("data_hold", 32'(if1.DATA), 32'(prev_data));
      end
      prev_valid = if1.valid;
      prev_data  = if1.DATA;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected summary", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    int k;
    int n;
    int lows;
    exp_t x;
    if1.start = 1'b0;
    if1.cont  = 1'b0;
    if2.start = 1'b0;
    if2.cont  = 1'b0;
    repeat (3) @(negedge CLK);

    chk("rst_sample", 32'(if1.SAMPLE), 32'd0);
    chk("rst_dac", 32'(if1.DAC_CODE), 32'd0);
    chk("rst_data", 32'(if1.DATA), 32'd0);
    chk("rst_valid", 32'(if1.valid), 32'd0);
    chk("rst_busy", 32'(if1.busy), 32'd0);
    #2 reset = 1'b1;
    @(negedge CLK);

    // Directed 0x2A5 with track/hold timing.
    m = cyc;
    issue(10'h2A5);
    chk("t1_sample_c1", 32'(if1.SAMPLE), 32'd1);
    chk("t1_busy_c1", 32'(if1.busy), 32'd1);
    @(negedge CLK);
    chk("t1_sample_c2", 32'(if1.SAMPLE), 32'd1);
    @(negedge CLK);
    chk("t1_sample_c3", 32'(if1.SAMPLE), 32'd0);
    chk("t1_dac_mid_c3", 32'(if1.DAC_CODE), 32'h200);
    wait_done(60);

    // Full scale and zero.
    issue(10'h3FF);
    wait_done(60);
    issue(10'h000);
    wait_done(60);

    // start held for 40 cycles: one accepted now, one right after IDLE.
    @(negedge CLK);
    m = cyc;
    vin1 = 10'h155;
    if1.start = 1'b1;
    x.data = sar_ref(10'h155);
    x.cyc = m + LAT;
    sb.push_back(x);
    x.cyc = m + LAT + 1 + LAT;
    sb.push_back(x);
    repeat (40) @(negedge CLK);
    if1.start = 1'b0;
    chk("hold_busy_c40", 32'(if1.busy), 32'd1);
    wait_done(80);

    // Continuous mode, three results 33 cycles apart, cont dropped during the third.
    @(negedge CLK);
    m = cyc;
    lows = 0;
    vin1 = 10'h100;
    if1.cont = 1'b1;
    x.data = sar_ref(10'h100); x.cyc = m + LAT;     sb.push_back(x);
    x.data = sar_ref(10'h155); x.cyc = m + 2 * LAT; sb.push_back(x);
    x.data = sar_ref(10'h3AA); x.cyc = m + 3 * LAT; sb.push_back(x);
    for (int i = 1; i <= 3 * LAT; i++) begin
      @(negedge CLK);
      if (!if1.busy) lows++;
      if (i == LAT) vin1 = 10'h155;
      if (i == 2 * LAT) vin1 = 10'h3AA;
      if (i == 2 * LAT + 4) if1.cont = 1'b0;
    end
    chk("cont_busy_low_cycles", 32'(lows), 32'd0);
    @(negedge CLK);
    chk("cont_busy_after_stop", 32'(if1.busy), 32'd0);
    wait_done(60);

    // Reset in the middle of a conversion.
    m = cyc;
    issue(10'h2A5);
    while (cyc < m + 15) @(negedge CLK);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_sample", 32'(if1.SAMPLE), 32'd0);
    chk("mid_rst_dac", 32'(if1.DAC_CODE), 32'd0);
    chk("mid_rst_busy", 32'(if1.busy), 32'd0);
    chk("mid_rst_data", 32'(if1.DATA), 32'd0);
    chk("mid_rst_valid", 32'(if1.valid), 32'd0);
    sb.delete();
    repeat (2) @(negedge CLK);
    #2 reset = 1'b1;
    repeat (40) @(negedge CLK);
    chk("post_rst_idle_busy", 32'(if1.busy), 32'd0);
    issue(10'h2A5);
    wait_done(60);

    // Random codes with a dropped start pulse inside each conversion.
    for (int r = 0; r < 6; r++) begin
      m = cyc;
      issue(10'($urandom_range(0, 1023)));
      k = $urandom_range(2, 30);
      while (cyc < m + k) @(negedge CLK);
      if1.start = 1'b1;
      @(negedge CLK);
      if1.start = 1'b0;
      wait_done(60);
    end

    // Slower timing parameters on the second instance.
    m = cyc;
    vin2 = 10'h001;
    if2.start = 1'b1;
    @(negedge CLK);
    if2.start = 1'b0;
    n = 1;
    while (!if2.valid && n < 80) begin
      @(negedge CLK);
      n++;
    end
    chk("p2_valid_cycle", 32'(cyc), 32'(m + LAT2));
    chk("p2_data", 32'(if2.DATA), 32'h001);
    repeat (3) @(negedge CLK);
    chk("p2_busy_end", 32'(if2.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
